jive_trap_seq: RTL and testbench
================================

Name: jive_trap_seq

Overview:
- Trap-entry sequencer and arbiter for the shared 16-bit CSR write/read port of the JiVe CSR file.
- On a CPU-acknowledged interrupt, it does three things:
  - picks the highest-priority pending cause from csr_mip;
  - signals exception-management entry;
  - writes mepc and mcause as 16-bit halves through the same port the CPU uses for CSR instructions.
- Sits between the CPU FSM / CSR-instruction path and the CSR file, and owns the port's select/index/data lines.

Parameters:
- MEPC_IDX, 6'h19, compressed CSR index of mepc (0x341).
- MCAUSE_IDX, 6'h1A, compressed CSR index of mcause (0x342).
- MTVEC_BASE, 32'h0000_0100, trap handler base address.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- csr_mip  in  3  pending+enabled interrupts {ext,tmr,sft} from the CSR file
- glb_int  in  1  global interrupt request from the CSR file
- trap_ack  in  1  CPU FSM at instruction boundary, accepts trap (1-cycle pulse)
- cur_pc  in  32  PC of the next instruction to execute, sampled on accept
- cpu_csr_req  in  1  CPU CSR access request
- cpu_csr_wr  in  1  CPU write strobe
- cpu_csr_rd  in  1  CPU read strobe
- cpu_msw_sel  in  1  CPU half select
- cpu_csr_idx  in  6  CPU CSR index
- cpu_csr_wdata  in  16  CPU write data
- cpu_csr_gnt  out  1  CPU access accepted this cycle
- csr_wr  out  1  shared port write strobe
- csr_rd  out  1  shared port read strobe
- msw_sel  out  1  shared port half select
- csr_idx  out  6  shared port index
- csr_wdata  out  16  shared port write data
- em_ena  out  1  exception-management entry pulse
- trap_busy  out  1  sequencer not IDLE
- trap_done  out  1  sequence complete pulse
- trap_pc  out  32  handler address, valid with trap_done

Behaviour:
- Reset: state=IDLE; all outputs 0; internal cause and pc latches are 0.
- States and transitions:
  - IDLE → EPC_L: when trap_ack & glb_int.
    - Latch cur_pc.
    - Latch cause by priority ext(11) > sft(3) > tmr(7), from csr_mip[2], [0], [1].
    - em_ena=1 for exactly this cycle.
  - EPC_L → EPC_H → CAU_L → CAU_H → DONE → IDLE, one cycle each, unconditional.
  - trap_ack with glb_int=0, or with csr_mip=0: ignored, stay IDLE, no em_ena.
- Shared port outputs are registered and appear the cycle after the source state/grant. Write data per state:
  - EPC_L: wr=1, msw_sel=0, idx=MEPC_IDX, wdata=pc[15:0].
  - EPC_H: wr=1, msw_sel=1, idx=MEPC_IDX, wdata=pc[31:16].
  - CAU_L: wr=1, msw_sel=0, idx=MCAUSE_IDX, wdata={12'b0,cause}.
  - CAU_H: wr=1, msw_sel=1, idx=MCAUSE_IDX, wdata=16'h8000 (interrupt bit).
  - DONE: trap_done=1 for 1 cycle, trap_pc valid; port idle.
- CPU arbitration:
  - cpu_csr_gnt = cpu_csr_req & (state==IDLE) & ~(trap_ack & glb_int). Combinational; trap start wins a same-cycle tie.
  - A granted CPU access is forwarded to the port registers the next cycle: wr, rd, msw_sel, idx, wdata copied.
  - Ungranted cycles drive wr=rd=0, idx=0, wdata=0.
  - The CPU holds its request until granted.
- Latency: trap_ack to first mepc write on port is 2 cycles; trap_ack to trap_done is 5 cycles.
- trap_busy=1 in every non-IDLE state.
- csr_mip changes after the latch cycle do not alter the latched cause.
- trap_ack while busy is ignored.
- rst_n low mid-sequence:
  - Immediately returns to IDLE and clears all outputs.
  - A partially written mepc is allowed; there is no resume.

Optional Feature:
- JIVE_TRAP_VEC_EN
  - Defined: vectored mode, trap_pc = MTVEC_BASE + {26'b0, cause, 2'b00}.
  - Undefined: direct mode, trap_pc = MTVEC_BASE for every cause.
  - mcause writes are identical in both modes.

Test Plan:
- Ext interrupt: csr_mip=3'b100, glb_int=1, trap_ack pulse, cur_pc=32'h0000_1234.
  - em_ena same cycle.
  - Port writes in order: (MEPC,0,16'h1234), (MEPC,1,16'h0000), (MCAUSE,0,16'h000B), (MCAUSE,1,16'h8000).
  - trap_done 5 cycles after ack; trap_pc=0x100 direct, 0x12C with JIVE_TRAP_VEC_EN.
- Priority: csr_mip=3'b011, accept.
  - mcause low write = 16'h0003 (sft beats tmr).
  - Vectored trap_pc=0x10C.
- Tie and blocking:
  - cpu_csr_req=1 in the same cycle as trap_ack&glb_int → cpu_csr_gnt=0.
  - gnt stays 0 while trap_busy.
  - gnt=1 the first IDLE cycle after trap_done.
  - CPU write (idx 6'h14, wdata 16'h0888) appears on the port one cycle after grant.
- Spurious accept: trap_ack=1 with glb_int=0 → no em_ena, no port writes, trap_busy stays 0, cpu_csr_gnt follows cpu_csr_req.
- Async reset in EPC_H: rst_n low → csr_wr, em_ena, trap_busy, trap_done all 0 without a clock edge; after release, state is IDLE and the CPU is granted.
- Cause stability: csr_mip drops to 0 one cycle after accept → sequence completes with the latched cause; a second trap_ack during CAU_L is ignored.

Source files
------------

// File: rtl/jive_trap_seq.sv
// jive_trap_seq: trap-entry sequencer and arbiter for the shared 16-bit CSR
// port of the JiVe CSR file. On an accepted interrupt it latches the PC and the
// highest-priority cause, then writes mepc and mcause as 16-bit halves.
// Optional macro JIVE_TRAP_VEC_EN selects vectored handler addressing;
// without it every trap goes to MTVEC_BASE (direct mode).
module jive_trap_seq #(
    parameter logic [5:0]  MEPC_IDX   = 6'h19,
    parameter logic [5:0]  MCAUSE_IDX = 6'h1A,
    parameter logic [31:0] MTVEC_BASE = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  csr_mip,
    input  logic        glb_int,
    input  logic        trap_ack,
    input  logic [31:0] cur_pc,
    input  logic        cpu_csr_req,
    input  logic        cpu_csr_wr,
    input  logic        cpu_csr_rd,
    input  logic        cpu_msw_sel,
    input  logic [5:0]  cpu_csr_idx,
    input  logic [15:0] cpu_csr_wdata,
    output logic        cpu_csr_gnt,
    output logic        csr_wr,
    output logic        csr_rd,
    output logic        msw_sel,
    output logic [5:0]  csr_idx,
    output logic [15:0] csr_wdata,
    output logic        em_ena,
    output logic        trap_busy,
    output logic        trap_done,
    output logic [31:0] trap_pc
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EPC_L = 3'd1,
        EPC_H = 3'd2,
        CAU_L = 3'd3,
        CAU_H = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cause_q, cause_d;
    logic [31:0] pc_q, pc_d;

    logic        wr_q, wr_d;
    logic        rd_q, rd_d;
    logic        msw_q, msw_d;
    logic [5:0]  idx_q, idx_d;
    logic [15:0] wdata_q, wdata_d;

    logic        trap_req;
    logic        accept;
    logic        gnt;
    logic [3:0]  mip_cause;
    logic [31:0] handler_pc;

    // A trap start needs both the CPU accept and the global request; it wins
    // any same-cycle tie against a CPU CSR access.
    assign trap_req = trap_ack & glb_int;
    assign accept   = trap_req & (state_q == IDLE) & (|csr_mip);
    assign gnt      = cpu_csr_req & (state_q == IDLE) & ~trap_req;

    // Priority encode the pending causes: external > software > timer.
    always_comb begin
        mip_cause = 4'd0;
        if (csr_mip[2]) begin
            mip_cause = 4'd11;
        end else if (csr_mip[0]) begin
            mip_cause = 4'd3;
        end else if (csr_mip[1]) begin
            mip_cause = 4'd7;
        end
    end

    // Next-state logic; cause and PC are captured only on the accept cycle so
    // later csr_mip changes cannot disturb the sequence.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EPC_L;
                    cause_d = mip_cause;
                    pc_d    = cur_pc;
                end
            end
            EPC_L:   state_d = EPC_H;
            EPC_H:   state_d = CAU_L;
            CAU_L:   state_d = CAU_H;
            CAU_H:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next value of the registered shared port: trap writes while sequencing,
    // a copy of the granted CPU access while idle, otherwise a quiet port.
    always_comb begin
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        msw_d   = 1'b0;
        idx_d   = 6'd0;
        wdata_d = 16'd0;
        case (state_q)
            IDLE: begin
                if (gnt) begin
                    wr_d    = cpu_csr_wr;
                    rd_d    = cpu_csr_rd;
                    msw_d   = cpu_msw_sel;
                    idx_d   = cpu_csr_idx;
                    wdata_d = cpu_csr_wdata;
                end
            end
            EPC_L: begin
                wr_d    = 1'b1;
                idx_d   = MEPC_IDX;
                wdata_d = pc_q[15:0];
            end
            EPC_H: begin
                wr_d    = 1'b1;
                msw_d   = 1'b1;
                idx_d   = MEPC_IDX;
                wdata_d = pc_q[31:16];
            end
            CAU_L: begin
                wr_d    = 1'b1;
                idx_d   = MCAUSE_IDX;
                wdata_d = {12'b0, cause_q};
            end
            CAU_H: begin
                wr_d    = 1'b1;
                msw_d   = 1'b1;
                idx_d   = MCAUSE_IDX;
                wdata_d = 16'h8000;
            end
            default: begin
                wr_d = 1'b0;
            end
        endcase
    end

    // State, latches and port registers; reset abandons any partial sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cause_q <= 4'd0;
            pc_q    <= 32'd0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            msw_q   <= 1'b0;
            idx_q   <= 6'd0;
            wdata_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            msw_q   <= msw_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef JIVE_TRAP_VEC_EN
    assign handler_pc = MTVEC_BASE + {26'b0, cause_q, 2'b00};
`else
    assign handler_pc = MTVEC_BASE;
`endif

    assign cpu_csr_gnt = gnt;
    assign em_ena      = accept;
    assign trap_busy   = (state_q != IDLE);
    assign trap_done   = (state_q == DONE);
    assign trap_pc     = (state_q == DONE) ? handler_pc : 32'd0;

    assign csr_wr    = wr_q;
    assign csr_rd    = rd_q;
    assign msw_sel   = msw_q;
    assign csr_idx   = idx_q;
    assign csr_wdata = wdata_q;

endmodule

// File: tb/tb_jive_trap_seq.sv
// tb_jive_trap_seq: directed and random stimulus for jive_trap_seq, checked
// against a cycle-indexed reference model (trap start time plus a schedule of
// expected port words). Honours JIVE_TRAP_VEC_EN for the handler address.
module tb_jive_trap_seq;

    localparam logic [5:0]  MEPC_IDX   = 6'h19;
    localparam logic [5:0]  MCAUSE_IDX = 6'h1A;
    localparam logic [31:0] MTVEC_BASE = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  csr_mip;
    logic        glb_int;
    logic        trap_ack;
    logic [31:0] cur_pc;
    logic        cpu_csr_req;
    logic        cpu_csr_wr;
    logic        cpu_csr_rd;
    logic        cpu_msw_sel;
    logic [5:0]  cpu_csr_idx;
    logic [15:0] cpu_csr_wdata;
    logic        cpu_csr_gnt;
    logic        csr_wr;
    logic        csr_rd;
    logic        msw_sel;
    logic [5:0]  csr_idx;
    logic [15:0] csr_wdata;
    logic        em_ena;
    logic        trap_busy;
    logic        trap_done;
    logic [31:0] trap_pc;

    always #5 clk = ~clk;

    jive_trap_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .csr_mip       (csr_mip),
        .glb_int       (glb_int),
        .trap_ack      (trap_ack),
        .cur_pc        (cur_pc),
        .cpu_csr_req   (cpu_csr_req),
        .cpu_csr_wr    (cpu_csr_wr),
        .cpu_csr_rd    (cpu_csr_rd),
        .cpu_msw_sel   (cpu_msw_sel),
        .cpu_csr_idx   (cpu_csr_idx),
        .cpu_csr_wdata (cpu_csr_wdata),
        .cpu_csr_gnt   (cpu_csr_gnt),
        .csr_wr        (csr_wr),
        .csr_rd        (csr_rd),
        .msw_sel       (msw_sel),
        .csr_idx       (csr_idx),
        .csr_wdata     (csr_wdata),
        .em_ena        (em_ena),
        .trap_busy     (trap_busy),
        .trap_done     (trap_done),
        .trap_pc       (trap_pc)
    );

    int testsRun  = 0;
    int failCount = 0;

    // Reference model state: cycle number, start cycle of the current trap,
    // latched cause/PC and a schedule of expected port words by cycle.
    int          cyc       = 0;
    int          trapStart = -100;
    logic [3:0]  mCause    = 4'd0;
    logic [31:0] mPc       = 32'd0;
    logic        lastGnt   = 1'b0;

    typedef struct {
        int          at;
        logic [24:0] val;
    } portEv_t;

    portEv_t portQ[$];

    function automatic logic [3:0] prioCause(input logic [2:0] mip);
        if (mip[2]) return 4'd11;
        if (mip[0]) return 4'd3;
        if (mip[1]) return 4'd7;
        return 4'd0;
    endfunction

    function automatic logic [24:0] portWord(input logic wr, input logic rd, input logic msw,
                                             input logic [5:0] idx, input logic [15:0] wdata);
        return {wr, rd, msw, idx, wdata};
    endfunction

    function automatic logic [24:0] expPortAt(input int c);
        logic [24:0] v;
        v = 25'd0;
        foreach (portQ[i]) begin
            if (portQ[i].at == c) v = portQ[i].val;
        end
        return v;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic ack, input logic glb, input logic [2:0] mip,
                                 input logic [31:0] pc, input logic req, input logic wr,
                                 input logic rd, input logic msw, input logic [5:0] idx,
                                 input logic [15:0] wdata);
        trap_ack      = ack;
        glb_int       = glb;
        csr_mip       = mip;
        cur_pc        = pc;
        cpu_csr_req   = req;
        cpu_csr_wr    = wr;
        cpu_csr_rd    = rd;
        cpu_msw_sel   = msw;
        cpu_csr_idx   = idx;
        cpu_csr_wdata = wdata;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 16'd0);
    endtask

    // Compare every output mid-cycle against the model, then advance the model
    // across the coming clock edge.
    task automatic checkOutput();
        logic        busy;
        logic        accept;
        logic        eGnt;
        logic        eDone;
        logic [31:0] ePc;
        logic [24:0] obsPort;
        @(negedge clk);
        busy    = (cyc > trapStart) && (cyc <= trapStart + 5);
        eDone   = (cyc == trapStart + 5);
        accept  = !busy && trap_ack && glb_int && (csr_mip != 3'b000);
        eGnt    = cpu_csr_req && !busy && !(trap_ack && glb_int);
        obsPort = {csr_wr, csr_rd, msw_sel, csr_idx, csr_wdata};
        checkVal("em_ena", 32'(em_ena), 32'(accept));
        checkVal("trap_busy", 32'(trap_busy), 32'(busy));
        checkVal("cpu_csr_gnt", 32'(cpu_csr_gnt), 32'(eGnt));
        checkVal("trap_done", 32'(trap_done), 32'(eDone));
        checkVal("port", 32'(obsPort), 32'(expPortAt(cyc)));
        if (eDone) begin
`ifdef JIVE_TRAP_VEC_EN
            ePc = MTVEC_BASE + 32'(mCause) * 4;
`else
            ePc = MTVEC_BASE;
`endif
            checkVal("trap_pc", trap_pc, ePc);
        end
        if (accept) begin
            trapStart = cyc;
            mCause    = prioCause(csr_mip);
            mPc       = cur_pc;
            portQ.push_back('{cyc + 2, portWord(1'b1, 1'b0, 1'b0, MEPC_IDX, mPc[15:0])});
            portQ.push_back('{cyc + 3, portWord(1'b1, 1'b0, 1'b1, MEPC_IDX, mPc[31:16])});
            portQ.push_back('{cyc + 4, portWord(1'b1, 1'b0, 1'b0, MCAUSE_IDX, {12'd0, mCause})});
            portQ.push_back('{cyc + 5, portWord(1'b1, 1'b0, 1'b1, MCAUSE_IDX, 16'h8000)});
        end
        if (eGnt) begin
            portQ.push_back('{cyc + 1, portWord(cpu_csr_wr, cpu_csr_rd, cpu_msw_sel,
                                                cpu_csr_idx, cpu_csr_wdata)});
        end
        lastGnt = eGnt;
        cyc++;
        for (int i = portQ.size() - 1; i >= 0; i--) begin
            if (portQ[i].at < cyc) portQ.delete(i);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        reqPending;
        logic        rWr;
        logic        rRd;
        logic        rMsw;
        logic [5:0]  rIdx;
        logic [15:0] rData;

        rst_n = 1'b0;
        applyIdle();
        #2;
        checkVal("reset_port_wr", 32'(csr_wr), 32'd0);
        checkVal("reset_wdata", 32'(csr_wdata), 32'd0);
        checkVal("reset_busy", 32'(trap_busy), 32'd0);
        checkVal("reset_done", 32'(trap_done), 32'd0);
        checkVal("reset_trap_pc", trap_pc, 32'd0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // External interrupt at PC 0x1234.
        applyStimulus(1'b1, 1'b1, 3'b100, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 16'd0);
        checkOutput();
        for (int i = 0; i < 6; i++) begin
            applyIdle();
            checkOutput();
        end

        // Software and timer pending together: software wins.
        applyStimulus(1'b1, 1'b1, 3'b011, 32'hDEAD_BEE0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 16'd0);
        checkOutput();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, 3'b011, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 16'd0);
            checkOutput();
        end

        // Tie with a CPU request; CPU holds until granted after the trap.
        applyStimulus(1'b1, 1'b1, 3'b001, 32'h0000_4000, 1'b1, 1'b1, 1'b0, 1'b0, 6'h14, 16'h0888);
        checkOutput();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, 3'b000, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 6'h14, 16'h0888);
            checkOutput();
        end
        applyIdle();
        checkOutput();

        // Spurious accepts: no global request, then no pending cause.
        applyStimulus(1'b1, 1'b0, 3'b111, 32'h0000_5555, 1'b1, 1'b0, 1'b1, 1'b1, 6'h05, 16'h0);
        checkOutput();
        applyIdle();
        checkOutput();
        applyStimulus(1'b1, 1'b1, 3'b000, 32'h0000_6666, 1'b1, 1'b1, 1'b0, 1'b0, 6'h07, 16'h1111);
        checkOutput();
        applyStimulus(1'b0, 1'b1, 3'b000, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 6'h07, 16'h1111);
        checkOutput();
        applyIdle();
        checkOutput();

        // Asynchronous reset while the upper mepc half is being issued.
        applyStimulus(1'b1, 1'b1, 3'b010, 32'hCAFE_0004, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 16'd0);
        checkOutput();
        applyIdle();
        checkOutput();
        applyIdle();
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("async_rst_wr", 32'(csr_wr), 32'd0);
        checkVal("async_rst_em", 32'(em_ena), 32'd0);
        checkVal("async_rst_busy", 32'(trap_busy), 32'd0);
        checkVal("async_rst_done", 32'(trap_done), 32'd0);
        trapStart = -100;
        portQ.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc = cyc + 2;
        applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1, 6'h0C, 16'hABCD);
        checkOutput();
        applyIdle();
        checkOutput();

        // Cause stability and a second accept while busy.
        applyStimulus(1'b1, 1'b1, 3'b100, 32'h8000_0010, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 16'd0);
        checkOutput();
        applyStimulus(1'b0, 1'b1, 3'b000, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 16'd0);
        checkOutput();
        applyStimulus(1'b0, 1'b1, 3'b000, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 16'd0);
        checkOutput();
        applyStimulus(1'b1, 1'b1, 3'b010, 32'h0000_0F00, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 16'd0);
        checkOutput();
        for (int i = 0; i < 4; i++) begin
            applyIdle();
            checkOutput();
        end

        // Random traffic with a CPU that holds requests until granted.
        reqPending = 1'b0;
        rWr = 1'b0; rRd = 1'b0; rMsw = 1'b0; rIdx = 6'd0; rData = 16'd0;
        for (int n = 0; n < 400; n++) begin
            if (!reqPending && ($urandom_range(0, 2) == 0)) begin
                reqPending = 1'b1;
                rWr   = 1'($urandom_range(0, 1));
                rRd   = ~rWr;
                rMsw  = 1'($urandom_range(0, 1));
                rIdx  = 6'($urandom_range(0, 63));
                rData = 16'($urandom);
            end
            applyStimulus(($urandom_range(0, 4) == 0), ($urandom_range(0, 3) != 0),
                          3'($urandom_range(0, 7)), $urandom, reqPending,
                          rWr, rRd, rMsw, rIdx, rData);
            checkOutput();
            if (lastGnt) reqPending = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
